// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing one FIFO write port among
// N_REQ producers. A grant lasts for a burst of up to BURST_LEN words and is
// followed by a single idle bubble before the next arbitration. Writes are
// gated against fifo_full, so the FIFO never sees a write while it is full.
//
// Optional build macro: ARB_THRESH_HOLD_EN. When it is defined, no new grant
// is issued while fifo_threshold is high. An in-progress burst is unaffected.
// When it is not defined, fifo_threshold is ignored.
module fifo_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    localparam int OW       = $clog2(N_REQ),
    localparam int BW       = $clog2(BURST_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ack,
    output logic [OW-1:0]             owner,
    output logic                      busy,
    input  logic                      fifo_full,
    input  logic                      fifo_threshold,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_wdata
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [OW-1:0]       last_owner_q, last_owner_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic                busy_q, busy_d;

    logic                sel_found_s;
    logic [OW-1:0]       sel_idx_s;
    logic                grant_ok_s;
    logic                fifo_wr_s;
    logic [N_REQ-1:0]    ack_s;
    logic [N_REQ-1:0]    owner_onehot_s;

`ifdef ARB_THRESH_HOLD_EN
    // Hold off new grants while the FIFO is at or above half full.
    assign grant_ok_s = ~fifo_threshold;
`else
    logic unused_thresh_s;
    assign unused_thresh_s = fifo_threshold;
    assign grant_ok_s      = 1'b1;
`endif

    assign owner_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = {OW{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            logic [OW-1:0] cand_v;
            logic          hit_v;
            cand_v      = OW'((int'(last_owner_q) + k) % N_REQ);
            hit_v       = req[cand_v] & ~sel_found_s;
            sel_idx_s   = hit_v ? cand_v : sel_idx_s;
            sel_found_s = sel_found_s | hit_v;
        end
    end

    // Write strobe and accept pulse: only the owner, only in a burst, never when full.
    always_comb begin
        fifo_wr_s = 1'b0;
        case (state_q)
            ST_IDLE:  fifo_wr_s = 1'b0;
            ST_BURST: fifo_wr_s = req[owner_q] & ~fifo_full;
            default:  fifo_wr_s = 1'b0;
        endcase
        ack_s = fifo_wr_s ? owner_onehot_s : {N_REQ{1'b0}};
    end

    // Next-state logic for grant, ownership and burst beat counting.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_d       = beat_q;
        busy_d       = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found_s && grant_ok_s) begin
                    gnt_d        = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx_s;
                    owner_d      = sel_idx_s;
                    last_owner_d = sel_idx_s;
                    beat_d       = {BW{1'b0}};
                    busy_d       = 1'b1;
                    state_d      = ST_BURST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (!req[owner_q]) begin
                    // Owner ran dry: end the burst early.
                    gnt_d   = {N_REQ{1'b0}};
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (fifo_wr_s) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_q == BW'(BURST_LEN - 1)) begin
                        gnt_d   = {N_REQ{1'b0}};
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BURST;
                    end
                end else begin
                    // Stalled on fifo_full: everything holds.
                    state_d = ST_BURST;
                end
            end
            default: begin
                gnt_d   = {N_REQ{1'b0}};
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; last_owner resets to N_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= {N_REQ{1'b0}};
            owner_q      <= {OW{1'b0}};
            last_owner_q <= OW'(N_REQ - 1);
            beat_q       <= {BW{1'b0}};
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_q       <= beat_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt        = gnt_q;
    assign busy       = busy_q;
    assign owner      = owner_q;
    assign ack        = ack_s;
    assign fifo_wr    = fifo_wr_s;
    assign fifo_wdata = req_data[int'(owner_q)*DATA_W +: DATA_W];

endmodule
